// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx slice.
// Optional feature: UART_TX_PARITY_EN adds an even-parity bit and a PARITY state.
package uart_pkg;

  typedef logic [7:0] byte_t;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Integer clocks per bit at the given line rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side bus of uart_tx: byte lanes, push count and free-space report.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int unsigned N = 8
);
  localparam int unsigned PW = $clog2(N + 1);

  byte_t [N-1:0] data_i;
  logic [PW-1:0] push;
  logic [PW-1:0] can_push;

  modport master (output data_i, output push, input can_push);
  modport slave  (input data_i, input push, output can_push);
endinterface

// File: rtl/uart_tx_fifo.sv
// Multi-byte-push / single-pop circular byte FIFO; DEPTH need not be a power of 2.
// The caller guarantees wr_n never exceeds the free space.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned N     = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(N + 1),
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  byte_t [N-1:0] data_i,
  input  logic [PW-1:0] wr_n,
  input  logic          rd,
  output logic [CW-1:0] count,
  output logic          empty,
  output byte_t         head
);

  byte_t         mem_q [DEPTH];
  byte_t         mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Single conditional subtract suffices: every sum stays below 2*DEPTH.
  function automatic int unsigned wrap(input int unsigned p);
    return (p >= DEPTH) ? p - DEPTH : p;
  endfunction

  // Lane i lands at wr_ptr+i so lane 0 is always popped first.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (i < 32'(wr_n)) mem_d[AW'(wrap(32'(wr_ptr_q) + i))] = data_i[i];
    end
    wr_ptr_d = AW'(wrap(32'(wr_ptr_q) + 32'(wr_n)));
    if (rd) rd_ptr_d = AW'(wrap(32'(rd_ptr_q) + 1));
    count_d = CW'(32'(count_q) + 32'(wr_n) - 32'(rd));
  end

  // Pointer/count state; storage needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, fed by a multi-byte-push FIFO.
// Define UART_TX_PARITY_EN for an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned boadrate = 115200,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned N        = 8
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, boadrate);
  localparam int unsigned BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  byte_t         shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [CW-1:0] count;
  logic          empty;
  byte_t         head;
  logic          pop;
  logic          load;
  logic          baud_end;
  logic [PW-1:0] wr_n;
  int unsigned   free_slots;
  int unsigned   cap;

  uart_tx_fifo #(.DEPTH(DEPTH), .N(N)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .data_i (bus.data_i),
    .wr_n   (wr_n),
    .rd     (pop),
    .count  (count),
    .empty  (empty),
    .head   (head)
  );

  // Free space saturated at N; uses registered count, so no same-cycle pop bypass.
  always_comb begin
    free_slots   = DEPTH - 32'(count);
    cap          = (free_slots < N) ? free_slots : N;
    bus.can_push = PW'(cap);
    wr_n         = (32'(bus.push) < cap) ? bus.push : PW'(cap);
  end

  // Frame sequencer; tx is derived from the next state so the pin is registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    load     = 1'b0;
    pop      = 1'b0;
    baud_end = (baud_q == BW'(CPB - 1));
    case (state_q)
      IDLE: begin
        if (!empty) load = 1'b1;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          if (!empty) load = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Shared by IDLE and end-of-STOP so back-to-back frames have no gap.
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      baud_d  = '0;
      state_d = START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default parameters (434 clocks per bit).
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME    = NBITS * CPB;
  localparam int STOP_POS = (NBITS - 1) * CPB + CPB / 2;
  localparam int NB       = 13;

  typedef struct {
    byte_t       data;
    logic        lo_end;
    logic        edge_b;
    logic        par;
    logic        stop;
    int unsigned t0;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  byte_t exp_bytes [NB] = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h04, 8'h03, 8'h02, 8'h01,
                            8'h09, 8'h14, 8'h13, 8'h12, 8'h11};

  uart_tx_if #(.N(8)) bus ();

  uart_tx #(.CLK_FREQ(50_000_000), .boadrate(115200), .DEPTH(8), .N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Line receiver: samples each bit mid-period plus the exact start-bit boundary.
  frame_t rx_q [$];
  frame_t cur;
  bit     mon_act = 1'b0;
  int     mon_pos = 0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_pos = 0;
        cur     = '{data: 8'h00, lo_end: 1'b0, edge_b: 1'b0, par: 1'b0, stop: 1'b0, t0: cyc};
      end
    end else begin
      mon_pos++;
      if (mon_pos == CPB - 1) cur.lo_end = tx;
      if (mon_pos == CPB) cur.edge_b = tx;
      for (int i = 0; i < 8; i++)
        if (mon_pos == CPB * (1 + i) + CPB / 2) cur.data[i] = tx;
      if (mon_pos == 9 * CPB + CPB / 2) cur.par = tx;
      if (mon_pos == STOP_POS) begin
        cur.stop = tx;
        rx_q.push_back(cur);
        mon_act = 1'b0;
      end
    end
  end

  task automatic test_reset;
    int bad;
    rst = 1'b1;
    bus.push = '0;
    bus.data_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx[%0d]: got %b want 1", i, tx); end
      n_cmp++;
      if (bus.can_push !== 4'd8) begin n_bad++; $display("FAIL reset_can_push[%0d]: got %0d want 8", i, bus.can_push); end
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL idle_tx_low_samples: got %0d want 0", bad); end
  endtask

  task automatic test_burst_full;
    bus.data_i = 64'h01020304_10203040;
    bus.push = 4'd8;
    @(negedge clk);
    n_cmp++;
    if (bus.can_push !== 4'd0) begin n_bad++; $display("FAIL full_can_push: got %0d want 0", bus.can_push); end
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL tx_after_enqueue: got %b want 1", tx); end
    bus.data_i = 64'hAAAAAAAA_AAAAAA09;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b0) begin n_bad++; $display("FAIL start_latency: got %b want 0", tx); end
    n_cmp++;
    if (bus.can_push !== 4'd1) begin n_bad++; $display("FAIL can_push_after_pop: got %0d want 1", bus.can_push); end
    @(negedge clk);
    n_cmp++;
    if (bus.can_push !== 4'd0) begin n_bad++; $display("FAIL one_lane_accepted: got %0d want 0", bus.can_push); end
    bus.push = '0;
    bus.data_i = '0;
  endtask

  task automatic test_partial_push;
    int budget = 6 * FRAME;
    while (bus.can_push !== 4'd4 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (budget == 0) begin
      n_bad++; $display("FAIL wait_can_push4: got %0d want 4 (timeout)", bus.can_push);
    end else begin
      n_cmp++;
      if (rx_q.size() != 4) begin n_bad++; $display("FAIL frames_at_can_push4: got %0d want 4", rx_q.size()); end
      bus.data_i = 64'h11121314;
      bus.push = 4'd4;
      @(negedge clk);
      bus.push = '0;
      bus.data_i = '0;
      n_cmp++;
      if (bus.can_push !== 4'd0) begin n_bad++; $display("FAIL can_push_after_partial: got %0d want 0", bus.can_push); end
    end
  endtask

  task automatic test_back_to_back;
    int budget = 14 * FRAME;
    while (rx_q.size() < NB && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (rx_q.size() < NB) begin
      n_bad++; $display("FAIL frame_count: got %0d want %0d (timeout)", rx_q.size(), NB);
    end else begin
      for (int i = 0; i < NB; i++) begin
        n_cmp++;
        if (rx_q[i].data !== exp_bytes[i]) begin
          n_bad++; $display("FAIL byte[%0d]: got %h want %h", i, rx_q[i].data, exp_bytes[i]);
        end
        n_cmp++;
        if ({rx_q[i].lo_end, rx_q[i].edge_b, rx_q[i].stop} !== {1'b0, exp_bytes[i][0], 1'b1}) begin
          n_bad++; $display("FAIL framing[%0d]: got %b%b%b want 0%b1", i,
                            rx_q[i].lo_end, rx_q[i].edge_b, rx_q[i].stop, exp_bytes[i][0]);
        end
`ifdef UART_TX_PARITY_EN
        n_cmp++;
        if (rx_q[i].par !== ^exp_bytes[i]) begin
          n_bad++; $display("FAIL parity[%0d]: got %b want %b", i, rx_q[i].par, ^exp_bytes[i]);
        end
`endif
        if (i > 0) begin
          n_cmp++;
          if (rx_q[i].t0 - rx_q[i-1].t0 != FRAME) begin
            n_bad++; $display("FAIL spacing[%0d]: got %0d want %0d", i, rx_q[i].t0 - rx_q[i-1].t0, FRAME);
          end
        end
      end
    end
  endtask

  task automatic test_drain;
    int bad = 0;
    repeat (CPB) @(negedge clk);
    n_cmp++;
    if (bus.can_push !== 4'd8) begin n_bad++; $display("FAIL drained_can_push: got %0d want 8", bus.can_push); end
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL drained_tx_low_samples: got %0d want 0", bad); end
    n_cmp++;
    if (rx_q.size() != NB) begin n_bad++; $display("FAIL drained_frames: got %0d want %0d", rx_q.size(), NB); end
  endtask

  task automatic test_reset_mid_frame;
    int budget = 10;
    int bad = 0;
    bus.data_i = 64'h03;
    bus.push = 4'd1;
    @(negedge clk);
    bus.push = '0;
    bus.data_i = '0;
    while (!mon_act && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (!mon_act) begin
      n_bad++; $display("FAIL abort_frame_start: got idle want start bit (timeout)");
    end else begin
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (tx !== 1'b1) begin n_bad++; $display("FAIL abort_tx: got %b want 1", tx); end
      n_cmp++;
      if (bus.can_push !== 4'd8) begin n_bad++; $display("FAIL abort_can_push: got %0d want 8", bus.can_push); end
      for (int i = 0; i < 2 * FRAME; i++) begin
        @(negedge clk);
        if (tx !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL post_abort_tx_low_samples: got %0d want 0", bad); end
      n_cmp++;
      if (rx_q.size() != NB) begin n_bad++; $display("FAIL post_abort_frames: got %0d want %0d", rx_q.size(), NB); end
    end
  endtask

  initial begin
    test_reset;
    test_burst_full;
    test_partial_push;
    test_back_to_back;
    test_drain;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
